rx_packet_fifo: RTL and testbench

//   Parametrised receive FIFO for the USB RX datapath: buffers received bytes between the

---
 rtl/rx_packet_fifo.sv | 116 +++++++++++
 tb/tb_rx_packet_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_packet_fifo.sv
// rx_packet_fifo
//   Receive FIFO for the USB RX datapath. The decoder writes bytes as pending
//   (uncommitted) entries. A commit makes the whole packet visible to the reader.
//   A discard rolls the packet back, and the reader never sees any of it.
//   Writes that hit a full FIFO corrupt the packet in flight. A later commit of
//   that packet is therefore turned into a discard.
//
// Ports
//   clk, rst     single clock; synchronous active-high reset
//   w_enable     write w_data as a pending entry (refused while full)
//   w_data       write data
//   commit       pending entries become readable
//   discard      drop all pending entries (wins over commit)
//   r_enable     pop one committed entry (refused while empty)
//   r_data       head of committed data, first-word fall-through
//   empty        no committed entries
//   full         committed + pending == DEPTH
//   almost_full  committed + pending >= AF_THRESH
//   count        committed entries available to the reader
//   overflow     1-cycle pulse after a write attempted while full
//   underflow    1-cycle pulse after a read attempted while empty
//
// Handshake semantics: w_enable is a request that is accepted only when full=0
// at the clock edge. r_enable is a request that is accepted only when empty=0
// at the clock edge. There is no back-pressure beyond these flags. A refused
// request is reported through a one-cycle overflow or underflow pulse.
module rx_packet_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       w_enable,
  input  logic [DATA_WIDTH-1:0]      w_data,
  input  logic                       commit,
  input  logic                       discard,
  input  logic                       r_enable,
  output logic [DATA_WIDTH-1:0]      r_data,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int ADDR = $clog2(DEPTH);
  localparam int PW   = ADDR + 1;
  localparam logic [PW-1:0] DEPTH_LVL = PW'(DEPTH);
  localparam logic [PW-1:0] AF_LVL    = PW'(AF_THRESH);
  localparam logic [PW-1:0] ONE       = PW'(1);

  // The pointers carry one extra wrap bit, so full and empty stay distinct
  // when the occupancy is exactly DEPTH.
  logic [PW-1:0]         rd_ptr, cmt_ptr, wr_ptr;
  logic                  pkt_err;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] committed, total, wr_ptr_next;
  logic          do_write, do_read, drop_pkt;

  always_comb begin
    committed = cmt_ptr - rd_ptr;
    total     = wr_ptr - rd_ptr;
    empty       = (committed == '0);
    full        = (total == DEPTH_LVL);
    almost_full = (total >= AF_LVL);
    count       = committed;
    r_data      = mem[rd_ptr[ADDR-1:0]];

    // A commit of a packet that already lost a byte to overflow is a discard.
    drop_pkt    = discard | (commit & pkt_err);
    do_write    = w_enable & ~full & ~drop_pkt;
    do_read     = r_enable & ~empty;
    // wr_ptr_next lets a commit include a write issued in the same cycle.
    wr_ptr_next = do_write ? (wr_ptr + ONE) : wr_ptr;
  end

  // The storage has no reset. A reset only moves the pointers.
  always_ff @(posedge clk) begin
    if (do_write && !rst)
      mem[wr_ptr[ADDR-1:0]] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      cmt_ptr   <= '0;
      wr_ptr    <= '0;
      pkt_err   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= w_enable & full;
      underflow <= r_enable & empty;

      if (do_read)
        rd_ptr <= rd_ptr + ONE;

      if (drop_pkt) begin
        wr_ptr  <= cmt_ptr;
        pkt_err <= 1'b0;
      end else begin
        wr_ptr <= wr_ptr_next;
        if (commit) begin
          cmt_ptr <= wr_ptr_next;
          pkt_err <= 1'b0;
        end else if (w_enable && full) begin
          pkt_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_packet_fifo.sv
module tb_rx_packet_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       w_enable, commit, discard, r_enable;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       empty, full, almost_full, overflow, underflow;
  logic [3:0] count;

  int n_pass = 0;
  int n_chk  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  rx_packet_fifo #(.DATA_WIDTH(8), .DEPTH(8), .AF_THRESH(6)) dut (
    .clk(clk), .rst(rst), .w_enable(w_enable), .w_data(w_data),
    .commit(commit), .discard(discard), .r_enable(r_enable),
    .r_data(r_data), .empty(empty), .full(full), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    w_enable = 1'b1; w_data = d; tick(); w_enable = 1'b0;
  endtask

  task automatic cm();
    commit = 1'b1; tick(); commit = 1'b0;
  endtask

  task automatic ds();
    discard = 1'b1; tick(); discard = 1'b0;
  endtask

  task automatic rd();
    r_enable = 1'b1; tick(); r_enable = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    n_chk++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else n_pass++;
    n_chk++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else n_pass++;
    n_chk++; if (almost_full !== 1'b0) $display("FAIL reset_af: got %b want 0", almost_full); else n_pass++;
    n_chk++; if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    n_chk++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow); else n_pass++;
    n_chk++; if (underflow !== 1'b0) $display("FAIL reset_udf: got %b want 0", underflow); else n_pass++;
  endtask

  task automatic test_commit_read();
    wr(8'h96); wr(8'h3C); wr(8'hA5);
    n_chk++; if (empty !== 1'b1) $display("FAIL pending_hidden: empty got %b want 1", empty); else n_pass++;
    cm();
    n_chk++; if (empty !== 1'b0) $display("FAIL commit_empty: got %b want 0", empty); else n_pass++;
    n_chk++; if (count !== 4'd3) $display("FAIL commit_count: got %0d want 3", count); else n_pass++;
    n_chk++; if (r_data !== 8'h96) $display("FAIL read0: got %h want 96", r_data); else n_pass++;
    rd();
    n_chk++; if (r_data !== 8'h3C) $display("FAIL read1: got %h want 3c", r_data); else n_pass++;
    rd();
    n_chk++; if (r_data !== 8'hA5) $display("FAIL read2: got %h want a5", r_data); else n_pass++;
    rd();
    n_chk++; if (empty !== 1'b1) $display("FAIL drained_empty: got %b want 1", empty); else n_pass++;
    n_chk++; if (count !== 4'd0) $display("FAIL drained_count: got %0d want 0", count); else n_pass++;
  endtask

  task automatic test_discard();
    wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
    n_chk++; if (almost_full !== 1'b0) $display("FAIL af_at4: got %b want 0", almost_full); else n_pass++;
    ds();
    n_chk++; if (empty !== 1'b1) $display("FAIL discard_empty: got %b want 1", empty); else n_pass++;
    n_chk++; if (count !== 4'd0) $display("FAIL discard_count: got %0d want 0", count); else n_pass++;
    wr(8'h11); cm();
    n_chk++; if (r_data !== 8'h11) $display("FAIL after_discard_data: got %h want 11", r_data); else n_pass++;
    n_chk++; if (count !== 4'd1) $display("FAIL after_discard_count: got %0d want 1", count); else n_pass++;
    rd();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) begin
      wr(8'(8'h20 + i));
      if (i == 4) begin
        n_chk++; if (almost_full !== 1'b0) $display("FAIL af_at5: got %b want 0", almost_full); else n_pass++;
      end
      if (i == 5) begin
        n_chk++; if (almost_full !== 1'b1) $display("FAIL af_at6: got %b want 1", almost_full); else n_pass++;
      end
    end
    n_chk++; if (full !== 1'b1) $display("FAIL fill_full: got %b want 1", full); else n_pass++;
    n_chk++; if (almost_full !== 1'b1) $display("FAIL fill_af: got %b want 1", almost_full); else n_pass++;
    n_chk++; if (empty !== 1'b1) $display("FAIL fill_pending_empty: got %b want 1", empty); else n_pass++;
    wr(8'hFF);
    n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_pulse: got %b want 1", overflow); else n_pass++;
    tick();
    n_chk++; if (overflow !== 1'b0) $display("FAIL ovf_one_cycle: got %b want 0", overflow); else n_pass++;
    cm();
    n_chk++; if (empty !== 1'b1) $display("FAIL err_commit_empty: got %b want 1", empty); else n_pass++;
    n_chk++; if (full !== 1'b0) $display("FAIL err_commit_full: got %b want 0", full); else n_pass++;
    n_chk++; if (almost_full !== 1'b0) $display("FAIL err_commit_af: got %b want 0", almost_full); else n_pass++;
    wr(8'h77); cm();
    n_chk++; if (r_data !== 8'h77) $display("FAIL err_cleared_data: got %h want 77", r_data); else n_pass++;
    n_chk++; if (count !== 4'd1) $display("FAIL err_cleared_count: got %0d want 1", count); else n_pass++;
    rd();
  endtask

  task automatic test_underflow();
    rd();
    n_chk++; if (underflow !== 1'b1) $display("FAIL udf_pulse: got %b want 1", underflow); else n_pass++;
    tick();
    n_chk++; if (underflow !== 1'b0) $display("FAIL udf_one_cycle: got %b want 0", underflow); else n_pass++;
    n_chk++; if (count !== 4'd0) $display("FAIL udf_count: got %0d want 0", count); else n_pass++;
    wr(8'h5A); cm();
    n_chk++; if (r_data !== 8'h5A) $display("FAIL udf_ptr_data: got %h want 5a", r_data); else n_pass++;
    n_chk++; if (count !== 4'd1) $display("FAIL udf_ptr_count: got %0d want 1", count); else n_pass++;
    rd();
  endtask

  task automatic test_full_read();
    for (int i = 0; i < 8; i++) wr(8'(8'h80 + i));
    cm();
    n_chk++; if (count !== 4'd8) $display("FAIL full_count: got %0d want 8", count); else n_pass++;
    n_chk++; if (full !== 1'b1) $display("FAIL full_flag: got %b want 1", full); else n_pass++;
    // Write is refused because full is judged before the edge.
    w_enable = 1'b1; w_data = 8'hEE; r_enable = 1'b1; tick();
    w_enable = 1'b0; r_enable = 1'b0;
    n_chk++; if (overflow !== 1'b1) $display("FAIL full_rw_ovf: got %b want 1", overflow); else n_pass++;
    n_chk++; if (count !== 4'd7) $display("FAIL full_rw_count: got %0d want 7", count); else n_pass++;
    n_chk++; if (full !== 1'b0) $display("FAIL full_rw_full: got %b want 0", full); else n_pass++;
    ds();
    for (int i = 1; i < 8; i++) begin
      n_chk++;
      if (r_data !== 8'(8'h80 + i)) $display("FAIL full_drain[%0d]: got %h want %h", i, r_data, 8'(8'h80 + i));
      else n_pass++;
      rd();
    end
    n_chk++; if (empty !== 1'b1) $display("FAIL full_drain_empty: got %b want 1", empty); else n_pass++;
  endtask

  task automatic test_back_to_back();
    w_enable = 1'b1; w_data = 8'h33; commit = 1'b1; tick();
    w_enable = 1'b0; commit = 1'b0;
    n_chk++; if (count !== 4'd1) $display("FAIL wr_commit_count: got %0d want 1", count); else n_pass++;
    n_chk++; if (r_data !== 8'h33) $display("FAIL wr_commit_data: got %h want 33", r_data); else n_pass++;
    w_enable = 1'b1; w_data = 8'h44; r_enable = 1'b1; tick();
    w_enable = 1'b0; r_enable = 1'b0;
    n_chk++; if (empty !== 1'b1) $display("FAIL rw_pending_empty: got %b want 1", empty); else n_pass++;
    cm();
    n_chk++; if (r_data !== 8'h44) $display("FAIL rw_commit_data: got %h want 44", r_data); else n_pass++;
    rd();
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) begin
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        exp_q.push_back(d);
        wr(d);
      end
      cm();
      n_chk++; if (count !== 4'd5) $display("FAIL wrap_count[%0d]: got %0d want 5", r, count); else n_pass++;
      for (int i = 0; i < 5; i++) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        n_chk++;
        if (r_data !== e) $display("FAIL wrap_data[%0d.%0d]: got %h want %h", r, i, r_data, e);
        else n_pass++;
        rd();
      end
    end
    n_chk++; if (empty !== 1'b1) $display("FAIL wrap_empty: got %b want 1", empty); else n_pass++;
    // A commit and a discard in the same cycle: the discard wins.
    wr(8'hC1); wr(8'hC2); wr(8'hC3);
    commit = 1'b1; discard = 1'b1; tick(); commit = 1'b0; discard = 1'b0;
    n_chk++; if (empty !== 1'b1) $display("FAIL cd_empty: got %b want 1", empty); else n_pass++;
    n_chk++; if (count !== 4'd0) $display("FAIL cd_count: got %0d want 0", count); else n_pass++;
    wr(8'h42); cm();
    n_chk++; if (r_data !== 8'h42) $display("FAIL cd_next_data: got %h want 42", r_data); else n_pass++;
    // A reset mid-packet clears both committed and pending data.
    wr(8'h01); cm(); wr(8'h02); wr(8'h03);
    rst = 1'b1; tick(); rst = 1'b0;
    n_chk++; if (empty !== 1'b1) $display("FAIL midrst_empty: got %b want 1", empty); else n_pass++;
    n_chk++; if (count !== 4'd0) $display("FAIL midrst_count: got %0d want 0", count); else n_pass++;
    n_chk++; if (almost_full !== 1'b0) $display("FAIL midrst_af: got %b want 0", almost_full); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; w_enable = 1'b0; w_data = 8'h00;
    commit = 1'b0; discard = 1'b0; r_enable = 1'b0;
    test_reset();
    test_commit_read();
    test_discard();
    test_overflow();
    test_underflow();
    test_full_read();
    test_back_to_back();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
